// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the register-file write arbiter and its SAD queue.
package wb_arb_pkg;

    localparam int REG_W         = 5;
    localparam int DATA_W        = 32;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  regnum;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Register $0 never holds state, so it never matches anything.
    function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/wb_arb_queue.sv
// Ordered circular buffer of pending SAD writes with squash-by-register and a
// per-entry lookup match vector for hazard detection.
module wb_arb_queue
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push,
    input  logic [REG_W-1:0]             push_reg,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    input  logic                         squash_en,
    input  logic [REG_W-1:0]             squash_reg,
    input  logic [REG_W-1:0]             lookup_a,
    input  logic [REG_W-1:0]             lookup_b,
    output wb_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH-1:0]             match
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]        head_ptr_reg;
    logic [PTR_W-1:0]        tail_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    wb_entry_t [DEPTH-1:0]   slots;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            wb_entry_t slot_reg;

            // A push into this slot outranks a squash: the incoming value is newer.
            always_ff @(posedge clk) begin
                if (srst) begin
                    slot_reg <= '0;
                end else if (push && (tail_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= '{valid: 1'b1, regnum: push_reg, data: push_data};
                end else if ((pop && (head_ptr_reg == PTR_W'(gi))) ||
                             (squash_en && (slot_reg.regnum == squash_reg))) begin
                    slot_reg.valid <= 1'b0;
                end
            end

            assign slots[gi] = slot_reg;
            assign match[gi] = slot_reg.valid &&
                               (reg_hit(lookup_a, slot_reg.regnum) ||
                                reg_hit(lookup_b, slot_reg.regnum));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
        end else begin
            if (push) begin
                tail_ptr_reg <= tail_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                head_ptr_reg <= head_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = slots[head_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between MEM/WB writeback (always wins) and
// queued SAD results; flags decode hazards. Optional macro: WB_ARB_BYPASS_EN.
module regfile_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         MEM_WB_RegWrite,
    input  logic [REG_W-1:0]             MEM_WB_WriteRegister,
    input  logic [DATA_W-1:0]            WB_WriteData,
    input  logic                         sad_req,
    input  logic [REG_W-1:0]             sad_reg,
    input  logic [DATA_W-1:0]            sad_data,
    output logic                         sad_ready,
    output logic                         RF_RegWrite,
    output logic [REG_W-1:0]             RF_WriteRegister,
    output logic [DATA_W-1:0]            RF_WriteData,
    input  logic [REG_W-1:0]             ID_rs,
    input  logic [REG_W-1:0]             ID_rt,
    output logic                         pend_hazard,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t          head;
    logic [DEPTH-1:0]   match;
    logic               accept;
    logic               bypass;
    logic               push;
    logic               pop;
    logic               head_present;
    logic               squash_en;
    logic               sad_hit;

    // Readiness depends on registered occupancy only, never on a same-cycle pop.
    assign sad_ready    = queue_count < CNT_W'(DEPTH);
    assign accept       = sad_req && sad_ready;
    assign head_present = queue_count != '0;

`ifdef WB_ARB_BYPASS_EN
    assign bypass = (queue_count == '0) && !MEM_WB_RegWrite && sad_req && (sad_reg != '0);
`else
    assign bypass = 1'b0;
`endif

    // Writes to $0 are accepted and dropped rather than queued.
    assign push = accept && (sad_reg != '0) && !bypass;

    // An invalid head never needs the port, so it retires even under a pipeline write.
    assign pop       = head_present && (!head.valid || !MEM_WB_RegWrite);
    assign squash_en = MEM_WB_RegWrite && (MEM_WB_WriteRegister != '0);

    wb_arb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (Clk),
        .srst       (Rst),
        .push       (push),
        .push_reg   (sad_reg),
        .push_data  (sad_data),
        .pop        (pop),
        .squash_en  (squash_en),
        .squash_reg (MEM_WB_WriteRegister),
        .lookup_a   (ID_rs),
        .lookup_b   (ID_rt),
        .head       (head),
        .count      (queue_count),
        .match      (match)
    );

    always_comb begin
        RF_RegWrite      = 1'b0;
        RF_WriteRegister = '0;
        RF_WriteData     = '0;
        if (MEM_WB_RegWrite) begin
            RF_RegWrite      = 1'b1;
            RF_WriteRegister = MEM_WB_WriteRegister;
            RF_WriteData     = WB_WriteData;
        end else if (bypass) begin
            RF_RegWrite      = 1'b1;
            RF_WriteRegister = sad_reg;
            RF_WriteData     = sad_data;
        end else if (head_present && head.valid) begin
            RF_RegWrite      = 1'b1;
            RF_WriteRegister = head.regnum;
            RF_WriteData     = head.data;
        end
    end

    assign sad_hit     = accept && (reg_hit(ID_rs, sad_reg) || reg_hit(ID_rt, sad_reg));
    assign pend_hazard = (|match) || sad_hit;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed check of regfile_write_arbiter against a queue-based
// reference model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic              Clk;
    logic              Rst;
    logic              MEM_WB_RegWrite;
    logic [4:0]        MEM_WB_WriteRegister;
    logic [31:0]       WB_WriteData;
    logic              sad_req;
    logic [4:0]        sad_reg;
    logic [31:0]       sad_data;
    logic              sad_ready;
    logic              RF_RegWrite;
    logic [4:0]        RF_WriteRegister;
    logic [31:0]       RF_WriteData;
    logic [4:0]        ID_rs;
    logic [4:0]        ID_rt;
    logic              pend_hazard;
    logic [CNT_W-1:0]  queue_count;

    regfile_write_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .Clk                  (Clk),
        .Rst                  (Rst),
        .MEM_WB_RegWrite      (MEM_WB_RegWrite),
        .MEM_WB_WriteRegister (MEM_WB_WriteRegister),
        .WB_WriteData         (WB_WriteData),
        .sad_req              (sad_req),
        .sad_reg              (sad_reg),
        .sad_data             (sad_data),
        .sad_ready            (sad_ready),
        .RF_RegWrite          (RF_RegWrite),
        .RF_WriteRegister     (RF_WriteRegister),
        .RF_WriteData         (RF_WriteData),
        .ID_rs                (ID_rs),
        .ID_rt                (ID_rt),
        .pend_hazard          (pend_hazard),
        .queue_count          (queue_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit          valid;
        int unsigned r;
        logic [31:0] d;
    } ment_t;

    ment_t model_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hits(input int unsigned r, input logic [4:0] rs, input logic [4:0] rt);
        return (rs != 0 && r == rs) || (rt != 0 && r == rt);
    endfunction

    // One clock cycle: drive, compare against the model mid-cycle, advance the model.
    task automatic cycle(input bit rst, input bit pw, input logic [4:0] pwr, input logic [31:0] pwd,
                         input bit sr, input logic [4:0] srg, input logic [31:0] sd,
                         input logic [4:0] rs, input logic [4:0] rt);
        int          cnt;
        bit          ready;
        bit          acc;
        bit          exp_we;
        logic [4:0]  exp_r;
        logic [31:0] exp_d;
        bit          exp_hz;

        Rst = rst; MEM_WB_RegWrite = pw; MEM_WB_WriteRegister = pwr; WB_WriteData = pwd;
        sad_req = sr; sad_reg = srg; sad_data = sd; ID_rs = rs; ID_rt = rt;
        #3;

        cnt    = model_q.size();
        ready  = cnt < DEPTH;
        acc    = sr && ready;
        exp_we = 1'b0; exp_r = '0; exp_d = '0;
        if (pw) begin
            exp_we = 1'b1; exp_r = pwr; exp_d = pwd;
        end else if (cnt > 0 && model_q[0].valid) begin
            exp_we = 1'b1; exp_r = 5'(model_q[0].r); exp_d = model_q[0].d;
        end
        exp_hz = acc && hits(srg, rs, rt);
        foreach (model_q[i]) begin
            if (model_q[i].valid && hits(model_q[i].r, rs, rt)) exp_hz = 1'b1;
        end

        check_eq("queue_count", queue_count, cnt);
        check_eq("sad_ready", sad_ready, ready);
        check_eq("rf_we", RF_RegWrite, exp_we);
        if (exp_we) begin
            check_eq("rf_reg", RF_WriteRegister, exp_r);
            check_eq("rf_data", RF_WriteData, exp_d);
        end
        check_eq("pend_hazard", pend_hazard, exp_hz);
        if (RF_RegWrite)
            $display("t=%0t rf write r%0d = %08h (count %0d)", $time, RF_WriteRegister, RF_WriteData, queue_count);

        if (rst) begin
            model_q.delete();
        end else begin
            if (cnt > 0 && (!model_q[0].valid || !pw)) void'(model_q.pop_front());
            if (pw && pwr != 0) begin
                foreach (model_q[i]) if (model_q[i].r == pwr) model_q[i].valid = 1'b0;
            end
            if (acc && srg != 0) model_q.push_back('{valid: 1'b1, r: srg, d: sd});
        end

        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] rs);
        cycle(0, 0, 0, 0, 0, 0, 0, rs, 0);
    endtask

    initial begin
        Rst = 1'b1; MEM_WB_RegWrite = 0; MEM_WB_WriteRegister = 0; WB_WriteData = 0;
        sad_req = 0; sad_reg = 0; sad_data = 0; ID_rs = 0; ID_rt = 0;
        @(posedge Clk);
        #1;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);

        // Basic enqueue and drain with hazard on reg 9
        cycle(0, 0, 0, 0, 1, 9, 32'hA5A5, 9, 0);
        idle(9);
        idle(9);

        // Pipeline priority
        cycle(0, 0, 0, 0, 1, 3, 32'h3333, 0, 3);
        for (int i = 0; i < 3; i++) cycle(0, 1, 5, 32'h500 + i, 0, 0, 0, 0, 3);
        idle(3);
        idle(0);

        // Squash, then squash with a simultaneous newer SAD write
        cycle(0, 0, 0, 0, 1, 7, 32'h11, 7, 0);
        cycle(0, 1, 7, 32'h22, 0, 0, 0, 7, 0);
        idle(7);
        idle(7);
        cycle(0, 1, 2, 32'h99, 1, 7, 32'h11, 7, 0);
        cycle(0, 1, 7, 32'h22, 1, 7, 32'h33, 7, 0);
        for (int i = 0; i < 3; i++) idle(7);

        // Full queue under continuous pipeline writes, then drain
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 32'h100 + i, 1, 5'(10 + i), 32'hD0 + i, 12, 0);
        for (int i = 0; i < 6; i++) idle(12);

        // $0 handling
        cycle(0, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
        cycle(0, 1, 0, 32'hBEEF, 1, 4, 32'h44, 0, 0);
        idle(0);
        idle(0);

        // Reset mid-operation with three entries queued
        for (int i = 0; i < 3; i++) cycle(0, 1, 30, 32'h7, 1, 5'(20 + i), 32'hE0 + i, 21, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 21, 0);
        for (int i = 0; i < 4; i++) idle(21);

        // Randomized traffic with alternating light/heavy pipeline phases
        for (int n = 0; n < 1500; n++) begin
            int unsigned pw_pct;
            pw_pct = ((n / 200) % 2 == 1) ? 85 : 30;
            cycle($urandom_range(0, 149) == 0,
                  $urandom_range(0, 99) < pw_pct,
                  5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < 60,
                  5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
